// File: rtl/uart_tx.sv
// UART transmitter: input FIFO plus start/8 data (LSB first)/stop framing, one line bit per uart_clk.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 2
) (
    input  logic                          uart_clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          txd_o,
    output logic                          tx_busy_o,
    output logic                          tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   lvl_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0] mem [FIFO_DEPTH];
    ptr_t       wr_ptr, rd_ptr;
    lvl_t       count;
    logic       push, pop;

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic [7:0] shift, shift_next;
    logic       txd_next;
    logic       last_stop;

    // Ready looks only at the registered count, so a same-cycle pop cannot admit a push.
    assign tx_ready_o   = (count != lvl_t'(FIFO_DEPTH));
    assign push         = tx_valid_i && tx_ready_o;
    assign fifo_level_o = count;

    assign last_stop = (state == S_STOP) && (cnt == 3'(STOP_BITS - 1));
    assign pop       = ((state == S_IDLE) || last_stop) && (count != '0);

    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            count <= count + lvl_t'(push) - lvl_t'(pop);
        end
    end

    always_ff @(posedge uart_clk) begin
        if (push) mem[wr_ptr] <= tx_data_i;
    end

    // State register; txd is registered from the next-state decode so the line never glitches.
    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            shift <= '0;
            txd_o <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            shift <= shift_next;
            txd_o <= txd_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par;

    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset)    par <= 1'b0;
        else if (pop) par <= ^mem[rd_ptr];
    end
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (pop) state_next = S_START;
            S_START:  state_next = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (cnt == 3'd7) state_next = S_PARITY;
            S_PARITY: state_next = S_STOP;
`else
            S_DATA:   if (cnt == 3'd7) state_next = S_STOP;
`endif
            S_STOP:   if (last_stop) state_next = pop ? S_START : S_IDLE;
            default:  state_next = S_IDLE;
        endcase

        // One counter serves both data-bit and stop-bit positions; it restarts on every state change.
        cnt_next = ((state_next != state) || (state == S_IDLE)) ? 3'd0 : cnt + 3'd1;

        shift_next = shift;
        if (pop)                  shift_next = mem[rd_ptr];
        else if (state == S_DATA) shift_next = {1'b0, shift[7:1]};
    end

    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_next = par;
`endif
            default:  txd_next = 1'b1;
        endcase
        tx_busy_o = (state != S_IDLE);
        tx_done_o = last_stop;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line decoder rebuilds bytes from txd and is compared to what was pushed.
module tb_uart_tx;
    localparam int DEPTH = 4;
    localparam int SB    = 2;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F = 9 + PAR + SB;

    logic       uart_clk = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, txd, tx_busy, tx_done;
    logic [2:0] fifo_level;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] rx_q[$];
    int         done_q[$];
    int         bad   = 0;
    int         stray = 0;

    uart_tx #(.FIFO_DEPTH(DEPTH), .STOP_BITS(SB)) dut (
        .uart_clk     (uart_clk),
        .reset        (reset),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .txd_o        (txd),
        .tx_busy_o    (tx_busy),
        .tx_done_o    (tx_done),
        .fifo_level_o (fifo_level)
    );

    always #5 uart_clk = ~uart_clk;
    always @(posedge uart_clk) cyc <= cyc + 1;

    // Expected line bits of one frame, index 0 = start bit; unused upper bits stay high.
    function automatic logic [15:0] frame_bits(input logic [7:0] b);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = b[i];
        if (PAR != 0) f[9] = ^b;
        return f;
    endfunction

    // Line decoder: behaves like a receiver sampling mid-bit.
    initial begin
        int         p;
        logic [7:0] b;
        logic       ok;
        p = -1; b = '0; ok = 1'b1;
        forever begin
            @(negedge uart_clk);
            if (reset) begin
                p = -1;
            end else if (p < 0) begin
                if (tx_done !== 1'b0) stray++;
                if (txd === 1'b0) begin p = 1; b = '0; ok = 1'b1; end
            end else begin
                if (p <= 8) b[p - 1] = txd;
                else if (PAR != 0 && p == 9) begin if (txd !== ^b) ok = 1'b0; end
                else if (txd !== 1'b1) ok = 1'b0;
                if (tx_done !== (p == F - 1)) ok = 1'b0;
                if (p == F - 1) begin
                    rx_q.push_back(b);
                    done_q.push_back(cyc);
                    if (!ok) bad++;
                    p = -1;
                end else begin
                    p++;
                end
            end
        end
    end

    task automatic step();
        @(posedge uart_clk);
        #1;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        done_q.delete();
        bad   = 0;
        stray = 0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin step(); k++; end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((tx_busy || fifo_level != 0) && k < 2000) begin step(); k++; end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL drain_timeout: busy=%0b expected 0", tx_busy); end
        step(); step();
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        checks++; if (txd !== 1'b1)        begin errors++; $display("FAIL reset_txd: got %0b expected 1", txd); end
        checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %0b expected 0", tx_busy); end
        checks++; if (tx_done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %0b expected 0", tx_done); end
        checks++; if (tx_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %0b expected 1", tx_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (txd !== 1'b1 || tx_busy !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: txd=%0b busy=%0b expected 1/0", txd, tx_busy); end
    endtask

    task automatic test_single();
        logic [15:0] fb;
        fb = frame_bits(8'hA5);
        clear_mon();
        tx_valid = 1'b1; tx_data = 8'hA5;
        step();
        tx_valid = 1'b0;
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_accept: got %0d expected 1", fifo_level); end
        checks++; if (txd !== 1'b1)        begin errors++; $display("FAIL single_idle_line: got %0b expected 1", txd); end
        for (int i = 0; i < F; i++) begin
            step();
            checks++; if (txd !== fb[i])
                begin errors++; $display("FAIL single_bit%0d: got %0b expected %0b", i, txd, fb[i]); end
            checks++; if (tx_done !== (i == F - 1))
                begin errors++; $display("FAIL single_done%0d: got %0b expected %0b", i, tx_done, (i == F - 1)); end
            checks++; if (tx_busy !== 1'b1)
                begin errors++; $display("FAIL single_busy%0d: got %0b expected 1", i, tx_busy); end
            if (i == 0) begin
                checks++; if (fifo_level !== 3'd0)
                    begin errors++; $display("FAIL single_level_pop: got %0d expected 0", fifo_level); end
            end
        end
        step();
        checks++; if (tx_busy !== 1'b0 || txd !== 1'b1 || tx_done !== 1'b0)
            begin errors++; $display("FAIL single_end: busy=%0b txd=%0b done=%0b expected 0/1/0", tx_busy, txd, tx_done); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat[4];
        pat = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1; tx_data = pat[i];
            step();
        end
        tx_valid = 1'b0;
        wait_rx(4, 4 * F + 20);
        checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== pat[i])
                begin errors++; $display("FAIL b2b_byte%0d: got %02h expected %02h", i, rx_q[i], pat[i]); end
        end
        for (int i = 1; i < done_q.size(); i++) begin
            checks++; if (done_q[i] - done_q[i - 1] != F)
                begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, done_q[i] - done_q[i - 1], F); end
        end
        checks++; if (bad != 0 || stray != 0)
            begin errors++; $display("FAIL b2b_framing: bad=%0d stray=%0d expected 0/0", bad, stray); end
        wait_idle();
    endtask

    // Producer holds valid high; the bench admits a byte only when ready was seen before the edge.
    task automatic stream(input int n, input int seed_mode, output logic [7:0] exp_q[$],
                          output int max_lvl, output int ready_bad, output int acc_cyc[$]);
        int         sent, guard;
        logic       acc;
        logic [7:0] d;
        exp_q.delete(); acc_cyc.delete();
        sent = 0; guard = 0; max_lvl = 0; ready_bad = 0;
        d = (seed_mode != 0) ? 8'($urandom) : 8'h10;
        while (sent < n && guard < 64 * F) begin
            tx_valid = 1'b1; tx_data = d;
            acc = tx_ready;
            if (tx_ready !== (fifo_level != 3'(DEPTH))) ready_bad++;
            step();
            guard++;
            if (acc) begin
                exp_q.push_back(d);
                acc_cyc.push_back(cyc);
                sent++;
                d = (seed_mode != 0) ? 8'($urandom) : d + 8'h01;
            end
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_full_stream();
        logic [7:0] exp_q[$];
        int         max_lvl, ready_bad;
        int         acc_cyc[$];
        clear_mon();
        stream(8, 0, exp_q, max_lvl, ready_bad, acc_cyc);
        checks++; if (exp_q.size() != 8) begin errors++; $display("FAIL full_sent: got %0d expected 8", exp_q.size()); end
        checks++; if (max_lvl != DEPTH)  begin errors++; $display("FAIL full_max_level: got %0d expected %0d", max_lvl, DEPTH); end
        checks++; if (ready_bad != 0)    begin errors++; $display("FAIL full_ready_rule: got %0d violations expected 0", ready_bad); end
        for (int k = 6; k < acc_cyc.size(); k++) begin
            checks++; if (acc_cyc[k] - acc_cyc[k - 1] != F)
                begin errors++; $display("FAIL full_refill%0d: got %0d expected %0d", k, acc_cyc[k] - acc_cyc[k - 1], F); end
        end
        wait_rx(8, 8 * F + 40);
        checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL full_rx_count: got %0d expected 8", rx_q.size()); end
        for (int i = 0; i < 8 && i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i])
                begin errors++; $display("FAIL full_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (bad != 0 || stray != 0)
            begin errors++; $display("FAIL full_framing: bad=%0d stray=%0d expected 0/0", bad, stray); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        clear_mon();
        tx_valid = 1'b1; tx_data = 8'hC3;
        step();
        tx_data = 8'h99;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if (txd !== 1'b0)        begin errors++; $display("FAIL mid_bit3: got %0b expected 0", txd); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL mid_level_before: got %0d expected 1", fifo_level); end
        reset = 1'b1;
        #1;
        checks++; if (txd !== 1'b1)        begin errors++; $display("FAIL mid_txd: got %0b expected 1", txd); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level: got %0d expected 0", fifo_level); end
        checks++; if (tx_busy !== 1'b0 || tx_done !== 1'b0)
            begin errors++; $display("FAIL mid_busy_done: busy=%0b done=%0b expected 0/0", tx_busy, tx_done); end
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 2 * F; i++) step();
        checks++; if (rx_q.size() != 0 || stray != 0)
            begin errors++; $display("FAIL mid_no_frame: frames=%0d stray=%0d expected 0/0", rx_q.size(), stray); end
        tx_valid = 1'b1; tx_data = 8'h81;
        step();
        tx_valid = 1'b0;
        wait_rx(1, F + 10);
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL mid_post_count: got %0d expected 1", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'h81 || bad != 0)
                begin errors++; $display("FAIL mid_post_frame: got %02h bad=%0d expected 81/0", rx_q[0], bad); end
        end
        wait_idle();
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0]  bytes[2];
        logic [11:0] lit[2];
        logic [11:0] l;
        bytes = '{8'h07, 8'h03};
        lit   = '{12'b1110_0000_1110, 12'b1100_0000_0110};
        for (int t = 0; t < 2; t++) begin
            l = lit[t];
            tx_valid = 1'b1; tx_data = bytes[t];
            step();
            tx_valid = 1'b0;
            for (int i = 0; i < 12; i++) begin
                step();
                checks++; if (txd !== l[i])
                    begin errors++; $display("FAIL parity_%02h_bit%0d: got %0b expected %0b", bytes[t], i, txd, l[i]); end
            end
            checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL parity_%02h_done: got %0b expected 1", bytes[t], tx_done); end
            wait_idle();
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         max_lvl, ready_bad, mis, gap_bad;
        int         acc_cyc[$];
        clear_mon();
        stream(32, 1, exp_q, max_lvl, ready_bad, acc_cyc);
        wait_rx(32, 32 * F + 40);
        checks++; if (rx_q.size() != 32) begin errors++; $display("FAIL rand_count: got %0d expected 32", rx_q.size()); end
        mis = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin
                errors++; mis++;
                if (mis <= 4) $display("FAIL rand_byte%0d: got %02h expected %02h", i, rx_q[i], exp_q[i]);
            end
        end
        gap_bad = 0;
        for (int i = 1; i < done_q.size(); i++) if (done_q[i] - done_q[i - 1] != F) gap_bad++;
        checks++; if (gap_bad != 0) begin errors++; $display("FAIL rand_spacing: got %0d bad gaps expected 0", gap_bad); end
        checks++; if (bad != 0 || stray != 0 || ready_bad != 0)
            begin errors++; $display("FAIL rand_framing: bad=%0d stray=%0d ready=%0d expected 0/0/0", bad, stray, ready_bad); end
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        wait_idle();
        test_back_to_back();
        test_full_stream();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
